elevator_controller: RTL and testbench

Sequences a single elevator car across NUM_FLOORS floors using a SCAN policy: it latches floor call requests, moves the car one floor at a time, and opens the door at each requested floor. It owns the current-floor state and drives a thermometer-coded floor vector (number of 1s = floor index) consumed by the 7-segment floor display decoder, plus direction/door status for the LEDs.

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elevator_controller_request_tracker.sv | 43 ++++
 rtl/elevator_controller.sv | 138 +++++++++++++
 tb/tb_elevator_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator controller slice.
package elevator_pkg;

  localparam int unsigned DEF_NUM_FLOORS = 7;
  localparam int unsigned DEF_FLOOR_W    = $clog2(DEF_NUM_FLOORS);

  typedef logic [DEF_FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  // Thermometer code: floor f -> f low bits set.
  function automatic logic [31:0] therm(input logic [31:0] f);
    return (32'd1 << f) - 32'd1;
  endfunction

endpackage

// File: rtl/elevator_controller_request_tracker.sv
// Latched call requests with clear-over-set, plus SCAN ahead/behind summaries
// relative to a reference floor.
module request_tracker
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FLOORS-1:0]         call_req,
  input  logic [$clog2(NUM_FLOORS)-1:0] ref_floor,
  input  logic                          dir_up,
  input  logic                          serve,
  output logic [NUM_FLOORS-1:0]         pending,
  output logic                          here_c,
  output logic                          ahead_c,
  output logic                          behind_c
);

  logic [NUM_FLOORS-1:0] sel;
  logic [NUM_FLOORS-1:0] below;
  logic [NUM_FLOORS-1:0] above;
  logic                  any_above;
  logic                  any_below;

  // Masks of floors strictly above/below the reference floor.
  always_comb begin
    sel       = NUM_FLOORS'(1) << ref_floor;
    below     = sel - NUM_FLOORS'(1);
    above     = ~(below | sel);
    any_above = |(pending & above);
    any_below = |(pending & below);
    here_c    = |(pending & sel);
    ahead_c   = dir_up ? any_above : any_below;
    behind_c  = dir_up ? any_below : any_above;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending | call_req) & ~(serve ? sel : '0);
  end

endmodule

// File: rtl/elevator_controller.sv
// Single-car SCAN elevator sequencer: floor counter, travel/door timer and
// the state machine; request bookkeeping lives in request_tracker.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int unsigned TRAVEL_CYCLES = 4,
  parameter int unsigned DOOR_CYCLES   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_FLOORS-1:0]         call_req,
  output logic [NUM_FLOORS-2:0]         floor,
  output logic [$clog2(NUM_FLOORS)-1:0] cur_floor,
  output logic [NUM_FLOORS-1:0]         pending,
  output logic                          dir_up,
  output logic                          moving,
  output logic                          door_open
);

  localparam int unsigned FW    = $clog2(NUM_FLOORS);
  localparam int unsigned FVW   = NUM_FLOORS - 1;
  localparam int unsigned MAX_T = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned TW    = $clog2(MAX_T + 1);

  state_t          state_q, state_n;
  logic [TW-1:0]   timer_q, timer_n;
  logic [FW-1:0]   cur_floor_n;
  logic            dir_up_n;
  logic            arrive_c;
  logic            here_c, ahead_c, behind_c;

  request_tracker #(.NUM_FLOORS(NUM_FLOORS)) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .call_req  (call_req),
    .ref_floor (cur_floor_n),
    .dir_up    (dir_up),
    .serve     (state_n == DOOR_OPEN),
    .pending   (pending),
    .here_c    (here_c),
    .ahead_c   (ahead_c),
    .behind_c  (behind_c)
  );

  // Floor counter steps on the last travel cycle; ends are hard limits.
  always_comb begin
    arrive_c    = ((state_q == MOVE_UP) || (state_q == MOVE_DOWN)) && (timer_q == TW'(1));
    cur_floor_n = cur_floor;
    if (arrive_c) begin
      if ((state_q == MOVE_UP) && (cur_floor != FW'(NUM_FLOORS - 1)))
        cur_floor_n = cur_floor + FW'(1);
      else if ((state_q == MOVE_DOWN) && (cur_floor != '0))
        cur_floor_n = cur_floor - FW'(1);
    end
  end

  always_comb begin
    state_n  = state_q;
    timer_n  = timer_q;
    dir_up_n = dir_up;
    unique case (state_q)
      IDLE: begin
        if (here_c) begin
          state_n = DOOR_OPEN;
          timer_n = TW'(DOOR_CYCLES);
        end else if (ahead_c) begin
          state_n = dir_up ? MOVE_UP : MOVE_DOWN;
          timer_n = TW'(TRAVEL_CYCLES);
        end else if (behind_c) begin
          dir_up_n = ~dir_up;
          state_n  = dir_up ? MOVE_DOWN : MOVE_UP;
          timer_n  = TW'(TRAVEL_CYCLES);
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (arrive_c) begin
          if (here_c) begin
            state_n = DOOR_OPEN;
            timer_n = TW'(DOOR_CYCLES);
          end else if (ahead_c) begin
            timer_n = TW'(TRAVEL_CYCLES);
          end else begin
            state_n = IDLE;
            timer_n = '0;
          end
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end
      DOOR_OPEN: begin
        // A fresh call for this floor keeps the door open a full period.
        if (call_req[cur_floor]) begin
          timer_n = TW'(DOOR_CYCLES);
        end else if (timer_q == TW'(1)) begin
          if (ahead_c) begin
            state_n = dir_up ? MOVE_UP : MOVE_DOWN;
            timer_n = TW'(TRAVEL_CYCLES);
          end else if (behind_c) begin
            dir_up_n = ~dir_up;
            state_n  = dir_up ? MOVE_DOWN : MOVE_UP;
            timer_n  = TW'(TRAVEL_CYCLES);
          end else begin
            state_n = IDLE;
            timer_n = '0;
          end
        end else begin
          timer_n = timer_q - TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cur_floor <= '0;
      dir_up    <= 1'b1;
      floor     <= '0;
      moving    <= 1'b0;
      door_open <= 1'b0;
    end else begin
      state_q   <= state_n;
      timer_q   <= timer_n;
      cur_floor <= cur_floor_n;
      dir_up    <= dir_up_n;
      floor     <= FVW'(therm(32'(cur_floor_n)));
      moving    <= (state_n == MOVE_UP) || (state_n == MOVE_DOWN);
      door_open <= (state_n == DOOR_OPEN);
    end
  end

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller with a door-stop scoreboard.
module tb_elevator_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] call_req;
  logic [5:0] floor;
  logic [2:0] cur_floor;
  logic [6:0] pending;
  logic       dir_up, moving, door_open;

  elevator_controller #(.NUM_FLOORS(7), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .call_req  (call_req),
    .floor     (floor),
    .cur_floor (cur_floor),
    .pending   (pending),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int nvec = 0;
  int nbad = 0;

  typedef struct {
    int fl;
    int dir;
    int start;
    int dur;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  function automatic logic [31:0] th(input int f);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < f; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic expect_door(input int fl, input int dir, input int start, input int dur);
    exp_t x;
    x.fl = fl; x.dir = dir; x.start = start; x.dur = dur;
    q.push_back(x);
  endtask

  // Caller is always parked on a falling edge.
  task automatic to_edge(input int t);
    if (ecnt > t) chk("schedule_late", ecnt, t);
    while (ecnt < t) @(negedge clk);
  endtask

  task automatic drive_at(input logic [6:0] mask, input int e);
    to_edge(e - 1);
    call_req = mask;
    @(negedge clk);
    call_req = '0;
  endtask

  // Monitor: every door period is matched against the next expected stop.
  initial begin : monitor
    logic prev;
    int   o_start, o_fl, o_dir, o_th;
    exp_t x;
    prev = 1'b0;
    o_start = 0; o_fl = 0; o_dir = 0; o_th = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("floor_therm", 32'(floor), th(int'(cur_floor)));
        chk("move_door_excl", 32'(moving & door_open), 32'd0);
        if (door_open && !prev) begin
          o_start = ecnt; o_fl = int'(cur_floor); o_dir = int'(dir_up); o_th = int'(floor);
        end
        if (!door_open && prev) begin
          if (q.size() == 0) begin
            nvec++; nbad++;
            $display("FAIL unexpected_door: door opened at floor %0d edge %0d, none expected", o_fl, o_start);
          end else begin
            x = q.pop_front();
            chk("door_floor", o_fl, x.fl);
            chk("door_therm", o_th, th(x.fl));
            chk("door_dir", o_dir, x.dir);
            chk("door_start", o_start, x.start);
            chk("door_len", ecnt - o_start, x.dur);
          end
        end
      end
      prev = door_open && !reset;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int e;
    reset = 1'b1;
    call_req = '0;
    repeat (3) @(negedge clk);
    chk("rst_cur_floor", cur_floor, 0);
    chk("rst_floor", floor, 0);
    chk("rst_pending", pending, 0);
    chk("rst_dir_up", dir_up, 1);
    chk("rst_moving", moving, 0);
    chk("rst_door", door_open, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_floor", floor, 0);
      chk("idle_door", door_open, 0);
      chk("idle_moving", moving, 0);
    end

    // Call at current floor 0
    e = ecnt + 2;
    expect_door(0, 1, e + 1, 3);
    drive_at(7'b0000001, e);
    to_edge(e + 1); chk("here_door_open", door_open, 1);
    to_edge(e + 4); chk("here_door_closed", door_open, 0);
    chk("here_pending", pending, 0);

    // Re-press while open extends the door
    e = ecnt + 2;
    expect_door(0, 1, e + 1, 4);
    drive_at(7'b0000001, e);
    drive_at(7'b0000001, e + 2);
    to_edge(e + 4); chk("repress_hold", door_open, 1);
    to_edge(e + 5); chk("repress_close", door_open, 0);

    // One-cycle call to floor 2
    e = ecnt + 2;
    expect_door(2, 1, e + 9, 3);
    drive_at(7'b0000100, e);
    chk("f2_pend_set", pending, 7'b0000100);
    to_edge(e + 1); chk("f2_moving", moving, 1);
    to_edge(e + 4); chk("f2_floor_e4", floor, 6'b000000);
    to_edge(e + 5); chk("f2_floor_e5", floor, 6'b000001);
    to_edge(e + 8); chk("f2_door_e8", door_open, 0);
    to_edge(e + 9); chk("f2_floor_e9", floor, 6'b000011);
    chk("f2_door_e9", door_open, 1);
    chk("f2_pend_clr", pending, 0);
    to_edge(e + 12); chk("f2_idle_moving", moving, 0);
    chk("f2_idle_door", door_open, 0);

    // Call for the arrival floor on the arrival edge
    e = ecnt + 2;
    expect_door(4, 1, e + 9, 3);
    drive_at(7'b0010000, e);
    drive_at(7'b0010000, e + 9);
    chk("same_edge_pend", pending, 0);
    chk("same_edge_door", door_open, 1);
    chk("same_edge_floor", cur_floor, 4);
    to_edge(e + 16); chk("same_edge_pend_end", pending, 0);
    chk("same_edge_door_end", door_open, 0);

    // Back down to floor 0
    e = ecnt + 2;
    expect_door(0, 0, e + 17, 3);
    drive_at(7'b0000001, e);
    to_edge(e + 20); chk("down0_dir", dir_up, 0);
    chk("down0_floor", cur_floor, 0);

    // Top floor from 0
    e = ecnt + 2;
    expect_door(6, 1, e + 25, 3);
    drive_at(7'b1000000, e);
    to_edge(e + 24); chk("top_floor_e24", floor, 6'b011111);
    to_edge(e + 25); chk("top_floor_e25", floor, 6'b111111);
    chk("top_door", door_open, 1);
    to_edge(e + 40); chk("top_hold_floor", cur_floor, 6);
    chk("top_hold_moving", moving, 0);

    // Return to bottom
    e = ecnt + 2;
    expect_door(0, 0, e + 25, 3);
    drive_at(7'b0000001, e);
    to_edge(e + 28); chk("bottom_floor", floor, 6'b000000);
    chk("bottom_dir", dir_up, 0);
    chk("bottom_moving", moving, 0);

    // SCAN: call 5, then call 1 once past floor 3 going up
    e = ecnt + 2;
    expect_door(5, 1, e + 21, 3);
    expect_door(1, 0, e + 40, 3);
    drive_at(7'b0100000, e);
    to_edge(e + 13); chk("scan_at3", cur_floor, 3);
    chk("scan_dir_up", dir_up, 1);
    chk("scan_moving", moving, 1);
    drive_at(7'b0000010, e + 14);
    to_edge(e + 43); chk("scan_end_floor", cur_floor, 1);
    chk("scan_end_dir", dir_up, 0);

    // Reset mid-move at floor 2
    e = ecnt + 2;
    drive_at(7'b1000000, e);
    to_edge(e + 6); chk("mid_floor", cur_floor, 2);
    chk("mid_moving", moving, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_floor", floor, 0);
    chk("mid_rst_cur", cur_floor, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_moving", moving, 0);
    chk("mid_rst_door", door_open, 0);
    chk("mid_rst_dir", dir_up, 1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_moving", moving, 0);
      chk("post_rst_cur", cur_floor, 0);
    end

    to_edge(ecnt + 3);
    if (q.size() != 0) begin
      nvec++; nbad++;
      $display("FAIL missing_door: %0d expected stops never occurred", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
